// File: rtl/proc_pkg.sv
// Shared definitions for the fetch sequencer: datapath widths, FSM state
// encoding and the branch-take decision helper.
package proc_pkg;

  localparam int PC_WIDTH     = 32;
  localparam int OFFSET_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Any of the branch conditions redirects to the same target address, so
  // jump > beq > bne priority collapses to a simple OR of the conditions.
  function automatic logic branch_take(input logic jump_en,
                                       input logic beq_en,
                                       input logic bne_en,
                                       input logic zero);
    return jump_en | (beq_en & zero) | (bne_en & ~zero);
  endfunction

endpackage

// File: rtl/next_pc_adder.sv
// Combinational next-PC computation: sequential increment and the
// PC-relative word-offset branch target, both modulo 2^32.
module next_pc_adder
  import proc_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_STEP = 32'd4
) (
  input  logic [PC_WIDTH-1:0]     pc,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic                    take,
  output logic [PC_WIDTH-1:0]     next_pc
);

  logic [PC_WIDTH-1:0] seq_pc_s;
  logic [PC_WIDTH-1:0] off_bytes_s;
  logic [PC_WIDTH-1:0] target_s;

  // Sign-extend the word offset and scale it to bytes, then add to PC + step.
  always_comb begin
    seq_pc_s    = pc + PC_STEP;
    off_bytes_s = {{(PC_WIDTH-OFFSET_WIDTH-2){offset[OFFSET_WIDTH-1]}}, offset, 2'b00};
    target_s    = seq_pc_s + off_bytes_s;
    if (take) begin
      next_pc = target_s;
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: five-state FSM that issues instruction fetches,
// waits on instruction/data memory, and advances the PC (sequential or branch).
// Optional macro FETCH_SEQUENCER_BNE_EN adds a BNE_ENABLE input
// (branch-if-not-equal, lowest priority below jump and beq).
module fetch_sequencer
  import proc_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'd0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = 32'd4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    BEQ_ENABLE,
  input  logic                    JUMP_ENABLE,
`ifdef FETCH_SEQUENCER_BNE_EN
  input  logic                    BNE_ENABLE,
`endif
  input  logic                    ZERO,
  input  logic [OFFSET_WIDTH-1:0] OFFSET,
  input  logic                    IMEM_BUSYWAIT,
  input  logic                    DMEM_BUSYWAIT,
  output logic [PC_WIDTH-1:0]     PC,
  output logic                    IMEM_READ,
  output logic                    INSTR_VALID,
  output logic                    STALL
);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] next_pc_s;
  logic                pc_load_s;
  logic                take_s;
  logic                bne_s;

`ifdef FETCH_SEQUENCER_BNE_EN
  assign bne_s = BNE_ENABLE;
`else
  assign bne_s = 1'b0;
`endif

  assign take_s = branch_take(JUMP_ENABLE, BEQ_ENABLE, bne_s, ZERO);

  next_pc_adder #(
    .PC_STEP (PC_STEP)
  ) u_next_pc_adder (
    .pc      (pc_r),
    .offset  (OFFSET),
    .take    (take_s),
    .next_pc (next_pc_s)
  );

  // State and PC registers; synchronous active-low reset discards any pending branch.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      if (pc_load_s) begin
        pc_r <= next_pc_s;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  // Next-state and PC-advance decision; each busywait only matters in its own phase.
  always_comb begin
    state_nxt_s = state_r;
    pc_load_s   = 1'b0;
    case (state_r)
      IDLE:  state_nxt_s = FETCH;
      FETCH: begin
        if (IMEM_BUSYWAIT) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      WAIT: begin
        if (IMEM_BUSYWAIT) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = EXEC;
        end
      end
      EXEC, HOLD: begin
        if (DMEM_BUSYWAIT) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = FETCH;
          pc_load_s   = 1'b1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control outputs are a pure decode of the state register.
  always_comb begin
    IMEM_READ   = 1'b0;
    INSTR_VALID = 1'b0;
    STALL       = 1'b0;
    case (state_r)
      FETCH: IMEM_READ = 1'b1;
      WAIT: begin
        IMEM_READ = 1'b1;
        STALL     = 1'b1;
      end
      EXEC: INSTR_VALID = 1'b1;
      HOLD: begin
        INSTR_VALID = 1'b1;
        STALL       = 1'b1;
      end
      default: begin
        IMEM_READ   = 1'b0;
        INSTR_VALID = 1'b0;
        STALL       = 1'b0;
      end
    endcase
  end

  assign PC = pc_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle table of inputs and the
// outputs expected after the following rising edge, checked through a
// scoreboard queue, plus hand-written throughput and reset-latency sequences.
module tb_fetch_sequencer;

  logic        CLK;
  logic        RESET;
  logic        BEQ_ENABLE;
  logic        JUMP_ENABLE;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic        IMEM_BUSYWAIT;
  logic        DMEM_BUSYWAIT;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic        INSTR_VALID;
  logic        STALL;
`ifdef FETCH_SEQUENCER_BNE_EN
  logic        BNE_ENABLE;
`endif

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        beq;
    logic        jmp;
    logic        zero;
    logic [7:0]  off;
    logic        ibw;
    logic        dbw;
    logic [31:0] pc;
    logic        ird;
    logic        vld;
    logic        stl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_sequencer #(
    .RESET_PC (32'd0),
    .PC_STEP  (32'd4)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BEQ_ENABLE    (BEQ_ENABLE),
    .JUMP_ENABLE   (JUMP_ENABLE),
`ifdef FETCH_SEQUENCER_BNE_EN
    .BNE_ENABLE    (BNE_ENABLE),
`endif
    .ZERO          (ZERO),
    .OFFSET        (OFFSET),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
    .PC            (PC),
    .IMEM_READ     (IMEM_READ),
    .INSTR_VALID   (INSTR_VALID),
    .STALL         (STALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic beq, input logic jmp, input logic zero,
                     input logic [7:0] off, input logic ibw, input logic dbw,
                     input logic [31:0] pc, input logic ird, input logic vld, input logic stl);
    vec_t v;
    v.rst = rst; v.beq = beq; v.jmp = jmp; v.zero = zero; v.off = off;
    v.ibw = ibw; v.dbw = dbw; v.pc = pc; v.ird = ird; v.vld = vld; v.stl = stl;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, record its expectation, then compare after the edge.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    @(negedge CLK);
    RESET         = v.rst;
    BEQ_ENABLE    = v.beq;
    JUMP_ENABLE   = v.jmp;
    ZERO          = v.zero;
    OFFSET        = v.off;
    IMEM_BUSYWAIT = v.ibw;
    DMEM_BUSYWAIT = v.dbw;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    check($sformatf("row%0d_pc", idx), PC, e.pc);
    check($sformatf("row%0d_imem_read", idx), {31'd0, IMEM_READ}, {31'd0, e.ird});
    check($sformatf("row%0d_instr_valid", idx), {31'd0, INSTR_VALID}, {31'd0, e.vld});
    check($sformatf("row%0d_stall", idx), {31'd0, STALL}, {31'd0, e.stl});
  endtask

  initial begin
    vec_t v;
    int   n;
    int   vcount;
    checks = 0;
    errors = 0;
    RESET = 1'b0; BEQ_ENABLE = 1'b0; JUMP_ENABLE = 1'b0; ZERO = 1'b0;
    OFFSET = 8'h00; IMEM_BUSYWAIT = 1'b0; DMEM_BUSYWAIT = 1'b0;
`ifdef FETCH_SEQUENCER_BNE_EN
    BNE_ENABLE = 1'b0;
`endif

    //   rst beq jmp zro off    ibw dbw  pc            ird vld stl
    add(0, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0); // reset -> IDLE
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0); // FETCH
    add(1, 0, 0, 0, 8'h00, 1, 0, 32'h0,        1, 0, 1); // WAIT 1
    add(1, 0, 0, 0, 8'h00, 1, 1, 32'h0,        1, 0, 1); // WAIT 2, dmem ignored
    add(1, 0, 0, 0, 8'h00, 1, 0, 32'h0,        1, 0, 1); // WAIT 3
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0); // EXEC
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h4,        1, 0, 0); // FETCH
    add(1, 0, 0, 0, 8'h00, 0, 1, 32'h4,        0, 1, 0); // EXEC, dmem ignored in FETCH
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h8,        1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h8,        0, 1, 0); // EXEC at PC=8
    add(1, 1, 0, 1, 8'hFE, 0, 0, 32'h4,        1, 0, 0); // beq taken -> 4
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h4,        0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h8,        1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h8,        0, 1, 0);
    add(1, 1, 0, 0, 8'hFE, 0, 0, 32'hC,        1, 0, 0); // beq not taken -> 12
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'hC,        0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 1, 32'hC,        0, 1, 1); // HOLD 1
    add(1, 0, 1, 0, 8'h7F, 0, 1, 32'hC,        0, 1, 1); // HOLD 2, jump not yet sampled
    add(1, 0, 1, 0, 8'h01, 1, 0, 32'h14,       1, 0, 0); // leave HOLD with jump +1 -> 20
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h14,       0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 1, 32'h14,       0, 1, 1); // HOLD
    add(1, 0, 0, 0, 8'h00, 0, 1, 32'h14,       0, 1, 1); // HOLD
    add(0, 0, 1, 0, 8'h10, 0, 1, 32'h0,        0, 0, 0); // reset in HOLD, branch discarded
    add(0, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0);
    add(1, 1, 1, 0, 8'h02, 0, 0, 32'hC,        1, 0, 0); // jump beats beq -> 12
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'hC,        0, 1, 0);
    add(1, 0, 1, 0, 8'hFB, 0, 0, 32'hFFFFFFFC, 1, 0, 0); // backward jump wraps
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'hFFFFFFFC, 0, 1, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0); // increment wraps to 0
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0);
    add(1, 1, 0, 0, 8'h10, 0, 0, 32'h4,        1, 0, 0); // beq with zero=0 not taken
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h4,        0, 1, 0);
    add(1, 0, 1, 1, 8'h7F, 0, 0, 32'h204,      1, 0, 0); // max forward jump
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h204,      0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 0, 0); // reset in EXEC
    add(1, 0, 0, 0, 8'h00, 1, 0, 32'h0,        1, 0, 0); // imem ignored in IDLE
    add(1, 0, 0, 0, 8'h00, 1, 0, 32'h0,        1, 0, 1); // WAIT
    add(0, 0, 0, 0, 8'h00, 1, 0, 32'h0,        0, 0, 0); // reset in WAIT
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        1, 0, 0);
    add(1, 0, 0, 0, 8'h00, 0, 0, 32'h0,        0, 1, 0); // EXEC at PC=0

    foreach (vecs[i]) begin
      run_vec(vecs[i], i);
    end

    // Zero-wait throughput: one instruction every two cycles from EXEC at PC=0.
    vcount = 0;
    for (int k = 0; k < 8; k++) begin
      v.rst = 1'b1; v.beq = 1'b0; v.jmp = 1'b0; v.zero = 1'b0; v.off = 8'h00;
      v.ibw = 1'b0; v.dbw = 1'b0;
      v.pc  = 32'd4 * (k / 2 + 1);
      v.ird = ((k % 2) == 0);
      v.vld = ((k % 2) == 1);
      v.stl = 1'b0;
      run_vec(v, 100 + k);
      if (INSTR_VALID) vcount++;
    end
    check("throughput_valid_count", vcount, 4);

    // Reset-release latency to the first valid instruction, with a bounded wait.
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("reset_pc", PC, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    n = 0;
    while (!INSTR_VALID && n < 6) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("first_valid_latency", n, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
